// File: rtl/hazard_scoreboard.sv
// Per-register in-flight write scoreboard with latency countdowns, RAW/WAW stall
// generation and a saturating stall counter. Optional bypass-aware RAW: HAZARD_FWD_EN.
module hazard_scoreboard #(
  parameter int REG_W = 4,
  parameter int NSRC  = 3,
  parameter int LAT_W = 3,
  parameter int CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   freeze,
  input  logic                   id_valid,
  input  logic [NSRC*REG_W-1:0]  id_src,
  input  logic [NSRC-1:0]        id_src_en,
  input  logic [REG_W-1:0]       id_dest,
  input  logic                   id_wb_en,
  input  logic [LAT_W-1:0]       id_lat,
  input  logic                   wb_valid,
  input  logic [REG_W-1:0]       wb_dest,
  output logic                   hazard_detected,
  output logic [NSRC-1:0]        fwd_sel,
  output logic [CNT_W-1:0]       stall_count
);

  localparam int NREG = 1 << REG_W;
  localparam logic [LAT_W-1:0] VAR_LAT = '1;

  logic [LAT_W-1:0] cnt_q [NREG];
  logic [LAT_W-1:0] cnt_d [NREG];
  logic [CNT_W-1:0] stall_count_q, stall_count_d;
  logic [NSRC-1:0]  fwd_sel_c;
  logic             raw_any, waw, issue;
  logic [LAT_W-1:0] load_lat;

  // An instruction is accepted only when it is valid, hazard-free, not frozen and
  // not being flushed; the hazard itself is reported independently of freeze.
  always_comb begin
    raw_any   = 1'b0;
    fwd_sel_c = '0;
    for (int i = 0; i < NSRC; i++) begin
      if (id_src_en[i] && cnt_q[id_src[i*REG_W +: REG_W]] != '0) begin
`ifdef HAZARD_FWD_EN
        if (cnt_q[id_src[i*REG_W +: REG_W]] == LAT_W'(1)) fwd_sel_c[i] = 1'b1;
        else raw_any = 1'b1;
`else
        raw_any = 1'b1;
`endif
      end
    end
    waw             = id_wb_en && (cnt_q[id_dest] != '0);
    hazard_detected = id_valid && (raw_any || waw);
    issue           = id_valid && !hazard_detected && !freeze && !flush;
    load_lat        = (id_lat == '0) ? LAT_W'(1) : id_lat;
  end

  assign fwd_sel     = fwd_sel_c;
  assign stall_count = stall_count_q;

  always_comb begin
    for (int r = 0; r < NREG; r++) begin
      cnt_d[r] = cnt_q[r];
      if (issue && id_wb_en && id_dest == REG_W'(r))
        cnt_d[r] = load_lat;
      else if (flush && cnt_q[r] != VAR_LAT)
        cnt_d[r] = '0;
      else if (wb_valid && wb_dest == REG_W'(r))
        cnt_d[r] = '0;
      else if (!freeze && cnt_q[r] != '0 && cnt_q[r] != VAR_LAT)
        cnt_d[r] = cnt_q[r] - LAT_W'(1);
    end
    stall_count_d = stall_count_q;
    if (hazard_detected && stall_count_q != '1)
      stall_count_d = stall_count_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < NREG; r++) cnt_q[r] <= '0;
      stall_count_q <= '0;
    end else begin
      for (int r = 0; r < NREG; r++) cnt_q[r] <= cnt_d[r];
      stall_count_q <= stall_count_d;
    end
  end

endmodule
